// File: rtl/gray_counter_conv.sv
// Up/down counter with registered binary and Gray views and a Gray-coded load path.
// Optional macro GRAY_STEP_CHECK_EN adds the step_err single-bit-change monitor.
module gray_counter_conv #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic             step_err
`endif
);

    localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_wrap_next;

    // Each binary bit is the XOR of all Gray bits at or above it; written per bit
    // so no bit of the vector feeds another bit of the same vector.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_g2b
            assign w_load_bin[gi] = ^load_gray[WIDTH-1:gi];
        end
    endgenerate

    always_comb begin
        w_bin_next  = r_bin;
        w_gray_next = r_gray;
        w_wrap_next = 1'b0;
        if (load) begin
            w_bin_next  = w_load_bin;
            w_gray_next = load_gray;
        end else if (en) begin
            if (up) begin
                w_bin_next  = r_bin + ONE;
                w_wrap_next = (r_bin == '1);
            end else begin
                w_bin_next  = r_bin - ONE;
                w_wrap_next = (r_bin == '0);
            end
            w_gray_next = w_bin_next ^ (w_bin_next >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= RST_VAL;
            r_gray <= RST_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign bin_q  = r_bin;
    assign gray_q = r_gray;
    assign wrap   = r_wrap;

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] r_gray_prev;
    logic             r_stepped;

    // Compares the registered Gray value against its predecessor, so a corrupted
    // binary or Gray register shows up as a multi-bit (or zero-bit) step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gray_prev <= RST_GRAY;
            r_stepped   <= 1'b0;
        end else begin
            r_gray_prev <= r_gray;
            r_stepped   <= en && !load;
        end
    end

    assign step_err = r_stepped && ($countones(r_gray ^ r_gray_prev) != 1);
`endif

endmodule

// File: tb/tb_gray_counter_conv.sv
// Scoreboard bench for gray_counter_conv (WIDTH=4, RST_VAL=0): reset, wrap in both
// directions, direction change, full load sweep, load priority and async reset.
module tb_gray_counter_conv;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] bin;
        logic [W-1:0] gray;
        logic         wrap;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_gray;
    logic [W-1:0] bin_q;
    logic [W-1:0] gray_q;
    logic         wrap;
`ifdef GRAY_STEP_CHECK_EN
    logic         step_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    exp_t         sb_q[$];
    logic [W-1:0] m_bin;

    gray_counter_conv #(.WIDTH(W), .RST_VAL('0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_gray (load_gray),
        .bin_q     (bin_q),
        .gray_q    (gray_q),
        .wrap      (wrap)
`ifdef GRAY_STEP_CHECK_EN
        ,
        .step_err  (step_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        logic         acc;
        acc = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Drive one cycle of stimulus, push the model's prediction, then compare.
    task automatic step(input logic l, input logic e, input logic u, input logic [W-1:0] lg);
        exp_t         ex;
        logic [W-1:0] prev_gray;
        @(negedge clk);
        load = l; en = e; up = u; load_gray = lg;
        prev_gray = ref_b2g(m_bin);
        ex.wrap = 1'b0;
        if (l) begin
            m_bin = ref_g2b(lg);
        end else if (e && u) begin
            ex.wrap = (m_bin == 4'hF);
            m_bin   = m_bin + 4'd1;
        end else if (e) begin
            ex.wrap = (m_bin == 4'h0);
            m_bin   = m_bin - 4'd1;
        end
        ex.bin  = m_bin;
        ex.gray = ref_b2g(m_bin);
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            ex = sb_q.pop_front();
            check_val("bin_q", 32'(bin_q), 32'(ex.bin));
            check_val("gray_q", 32'(gray_q), 32'(ex.gray));
            check_val("wrap", 32'(wrap), 32'(ex.wrap));
            $display("txn load=%b en=%b up=%b lg=%b -> bin=%b gray=%b wrap=%b", l, e, u, lg, bin_q, gray_q, wrap);
        end
        if (!l && e)
            check_val("gray_1bit", 32'($countones(gray_q ^ prev_gray)), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_gray = '0;
        m_bin = '0;
        repeat (2) @(negedge clk);
        check_val("rst_bin", 32'(bin_q), 32'd0);
        check_val("rst_gray", 32'(gray_q), 32'd0);
        check_val("rst_wrap", 32'(wrap), 32'd0);
        rst_n = 1'b1;

        // Up count through a full wrap and one more.
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 1'b1, '0);
            if (i == 14) check_val("up_gray_1000", 32'(gray_q), 32'h8);
            if (i == 15) check_val("up_wrap_pulse", 32'(wrap), 32'd1);
        end

        // Down count from 0001 across zero, then reverse direction.
        step(1'b1, 1'b0, 1'b0, 4'b0001);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        check_val("down_gray_1000", 32'(gray_q), 32'h8);
        check_val("down_wrap_pulse", 32'(wrap), 32'd1);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, '0);
        check_val("reverse_bin", 32'(bin_q), 32'hF);
        step(1'b0, 1'b1, 1'b1, '0);

        // Load every Gray code.
        for (int g = 0; g < 16; g++) begin
            step(1'b1, 1'b0, 1'b0, 4'(g));
            if (g == 11) check_val("g2b_1011", 32'(bin_q), 32'hD);
            if (g == 6)  check_val("g2b_0110", 32'(bin_q), 32'h4);
            if (g == 15) check_val("g2b_1111", 32'(bin_q), 32'hA);
        end

        // Load beats a wrapping increment.
        step(1'b1, 1'b0, 1'b0, 4'b1000);
        step(1'b1, 1'b1, 1'b1, 4'b0010);
        check_val("prio_bin", 32'(bin_q), 32'h3);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 4'b1111);

        // Asynchronous reset mid-count at 0101.
        step(1'b1, 1'b0, 1'b0, 4'b0111);
        step(1'b0, 1'b1, 1'b1, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        check_val("pre_rst_bin", 32'(bin_q), 32'h5);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_bin", 32'(bin_q), 32'd0);
        check_val("async_rst_gray", 32'(gray_q), 32'd0);
        check_val("async_rst_wrap", 32'(wrap), 32'd0);
        m_bin = '0;
        en = 1'b0; load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_counter_conv.md
Name: gray_counter_conv

Overview:
- Parametrised up/down counter that keeps binary and Gray-code views of one count value, with both views registered.
- Can be loaded with a Gray-coded value. The load path uses an N-bit Gray-to-binary XOR-prefix converter, so loaded values land in the same count sequence.
- Used as a pointer/position source wherever both encodings are needed: Gray for clock-domain crossing or encoder interfaces, binary for arithmetic.

Parameters:
- WIDTH, 4, counter width in bits; legal range ≥2.
- RST_VAL, 0, binary reset value of the count (Gray output resets to its Gray encoding).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load strobe; priority over en
- load_gray  input  WIDTH  Gray-coded load value
- bin_q  output  WIDTH  registered binary count
- gray_q  output  WIDTH  registered Gray count; always equals bin_q ^ (bin_q >> 1)
- wrap  output  1  one-cycle pulse, registered; indicates the count wrapped on the previous step
- step_err  output  1  present only with GRAY_STEP_CHECK_EN (see below)

Behaviour:
- Reset (rst_n low, asynchronous):
  - bin_q = RST_VAL
  - gray_q = RST_VAL ^ (RST_VAL >> 1)
  - wrap = 0
  - step_err = 0
- Release of reset is synchronous to the next rising clk edge; no count action on that edge unless en or load is high.
- Per-edge priority, highest first:
  1. load=1:
     - bin_q ← G2B(load_gray); gray_q ← load_gray.
     - wrap ← 0.
     - en and up are ignored.
  2. en=1, up=1:
     - bin_q ← bin_q + 1, modulo 2^WIDTH.
     - wrap ← 1 if bin_q was all-ones, else 0.
  3. en=1, up=0:
     - bin_q ← bin_q − 1, modulo 2^WIDTH.
     - wrap ← 1 if bin_q was 0, else 0.
  4. Otherwise: hold bin_q and gray_q; wrap ← 0.
- G2B converter:
  - b[WIDTH-1] = g[WIDTH-1]
  - b[i] = b[i+1] ^ g[i] for i = WIDTH-2 down to 0
  - Purely combinational on load_gray; implemented as a generate loop.
- gray_q is computed from the next binary value and registered in the same edge as bin_q.
  - No cycle skew between the two views.
  - gray_q must never be derived combinationally from bin_q at the output.
- Latency:
  - load or count request at edge N → new bin_q/gray_q visible after edge N.
  - wrap is high for exactly the cycle following the wrapping edge.
- Direction change while enabled takes effect on the same edge; no dead cycle.
- Consecutive counting steps change gray_q in exactly one bit, including at wrap.
- Loads may change gray_q in any number of bits.
- Reset asserted mid-count forces reset values immediately, independent of clk.

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- Defined:
  - Adds output step_err (1 bit) and an internal register holding the previous gray_q.
  - step_err pulses high for one cycle if gray_q changed by a Hamming distance ≠ 1 on an edge where a count step occurred (en=1, load=0).
  - Loads and hold cycles never flag.
  - Reset value is 0.
  - Intended as an integrity monitor against SEU or synthesis faults.
- Undefined:
  - Port step_err and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: WIDTH=4, RST_VAL=0, hold rst_n=0 → bin_q=0000, gray_q=0000, wrap=0. Assert rst_n low mid-count at bin_q=0101 → outputs return to 0 without a clk edge.
- Up-count wrap: en=1, up=1 for 17 cycles from 0.
  - gray_q follows 0000,0001,0011,0010,0110,…,1000, then 0000.
  - wrap=1 only in the cycle after 1111→0000.
  - Every step changes gray_q in exactly one bit.
- Down-count wrap: en=1, up=0 from bin_q=0001 → 0000, then 1111 (gray_q 1000), with wrap pulsed once after 0000→1111. Toggle up mid-run → direction reverses on the same edge.
- Load conversion: drive load=1 with load_gray sweeping all 16 values 0000..1111.
  - Each cycle bin_q equals the binary decode, e.g. load_gray 1011 → bin_q 1101; 0110 → 0100; 1111 → 1010.
  - gray_q equals load_gray.
- Load priority: load=1, en=1, up=1 simultaneously with bin_q=1111 and load_gray=0010 → bin_q=0011, wrap=0. Then hold en=0 for 3 cycles → outputs unchanged.
- GRAY_STEP_CHECK_EN and WIDTH=8:
  - Count 300 steps → step_err stays 0.
  - Force-flip an internal bin bit → step_err=1 for one cycle.
  - A load of 0x00→0xFF → step_err stays 0.
